lc3_fetch_buffer: RTL

LC3_FETCH_BUFFER -- requirements
Module: lc3_fetch_buffer

---
 rtl/lc3_fetch_buffer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lc3_fetch_buffer.sv
// LC-3 instruction fetch buffer: issues sequential imem reads and queues
// {instr, npc} pairs for decode, with branch redirect/flush support.
module lc3_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable_fetch,
  input  logic                     br_taken,
  input  logic [15:0]              taddr,
  output logic [15:0]              imem_addr,
  output logic                     imem_rd,
  input  logic [15:0]              imem_dout,
  output logic [15:0]              instr_out,
  output logic [15:0]              npc_out,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);

  logic [15:0]   pc_q, pc_d;
  logic [15:0]   tag_q, tag_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [15:0]   instr_mem_q [DEPTH];
  logic [15:0]   npc_mem_q   [DEPTH];

  logic [CW:0]   occupancy_s;
  logic          fetch_s;
  logic          push_s;
  logic          pop_s;
  logic          valid_s;

  // Occupancy counts the outstanding response so the queue can never overflow.
  always_comb begin
    occupancy_s = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    valid_s     = (count_q != CNT_ZERO);
    fetch_s     = reset_n & enable_fetch & ~br_taken & (occupancy_s < DEPTH_EXT);
    push_s      = inflight_q & ~br_taken;
    pop_s       = valid_s & instr_ready & ~br_taken;
  end

  // Next-state logic; a redirect overrides fetch, push and pop.
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (br_taken) begin
      pc_d       = taddr;
      inflight_d = 1'b0;
      wptr_d     = PTR_ZERO;
      rptr_d     = PTR_ZERO;
      count_d    = CNT_ZERO;
    end else begin
      if (fetch_s) begin
        pc_d  = pc_q + 16'd1;
        tag_d = pc_q + 16'd1;
      end else begin
        pc_d  = pc_q;
        tag_d = tag_q;
      end
      inflight_d = fetch_s;
      if (push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      tag_q      <= 16'h0000;
      inflight_q <= 1'b0;
      wptr_q     <= PTR_ZERO;
      rptr_q     <= PTR_ZERO;
      count_q    <= CNT_ZERO;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; entry contents are qualified by count, so no reset needed.
  always_ff @(posedge clock) begin
    if (push_s) begin
      instr_mem_q[wptr_q] <= imem_dout;
      npc_mem_q[wptr_q]   <= tag_q;
    end
  end

  // Head outputs are forced to zero whenever the queue is empty.
  always_comb begin
    imem_addr   = pc_q;
    imem_rd     = fetch_s;
    instr_valid = valid_s;
    count       = count_q;
    if (valid_s) begin
      instr_out = instr_mem_q[rptr_q];
      npc_out   = npc_mem_q[rptr_q];
    end else begin
      instr_out = 16'h0000;
      npc_out   = 16'h0000;
    end
  end

  lc3_fetch_buffer_chk #(.DEPTH(DEPTH)) u_chk (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_s),
    .count   (count_q)
  );

endmodule

// Simulation-only checks on queue occupancy.
module lc3_fetch_buffer_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clock,
  input logic                   reset_n,
  input logic                   push,
  input logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  a_no_push_when_full: assert property (
    @(posedge clock) disable iff (!reset_n) push |-> (count < DEPTH_C)
  );

  a_count_bounded: assert property (
    @(posedge clock) disable iff (!reset_n) count <= DEPTH_C
  );

endmodule
